usb_pkt_tx: RTL

USB_PKT_TX -- requirements
Module: usb_pkt_tx

---
 rtl/usb_pkt_tx.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/usb_pkt_tx.sv
// USB packet transmitter: turns a registered request (token, SOF, handshake or DATA)
// into a PID/field/payload/CRC byte stream with valid/ready flow control.
module usb_pkt_tx #(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_pid,
  input  logic [6:0]       req_addr,
  input  logic [3:0]       req_endp,
  input  logic [10:0]      req_frame,
  input  logic [LEN_W-1:0] req_len,
  input  logic             pl_valid,
  output logic             pl_ready,
  input  logic [7:0]       pl_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [7:0]       tx_data,
  output logic             tx_sop,
  output logic             tx_eop,
  output logic             tx_pid_en,
  output logic [3:0]       tx_pid,
  output logic             req_err
);

  typedef enum logic [2:0] {IDLE, PID, B1, B2, PAYLOAD, CRC_LO, CRC_HI} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);

  // Field bits enter LSB-first; result is the complemented remainder.
  function automatic logic [4:0] crc5_f(input logic [10:0] d);
    logic [4:0] c;
    c = '1;
    for (int unsigned i = 0; i < 11; i++) begin
      if (d[i] ^ c[4]) c = {c[3:0], 1'b0} ^ 5'b00101;
      else             c = {c[3:0], 1'b0};
    end
    return ~c;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    c = c_in;
    for (int unsigned i = 0; i < 8; i++) begin
      if (d[i] ^ c[15]) c = {c[14:0], 1'b0} ^ 16'h8005;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [4:0] rev5(input logic [4:0] v);
    logic [4:0] r;
    for (int unsigned i = 0; i < 5; i++) r[i] = v[4-i];
    return r;
  endfunction

  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int unsigned i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [3:0]       pid_q, pid_d;
  logic [6:0]       addr_q, addr_d;
  logic [3:0]       endp_q, endp_d;
  logic [10:0]      frame_q, frame_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [15:0]      crc16_q, crc16_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_sop_q, tx_sop_d;
  logic             tx_eop_q, tx_eop_d;
  logic             err_q, err_d;

  logic        xfer, slot_free, pl_fire, is_sof, reject;
  logic [10:0] crc5_field;
  logic [7:0]  b1_byte, b2_byte;
  logic [15:0] crc16_out;

  assign xfer       = tx_valid_q && tx_ready;
  assign slot_free  = !tx_valid_q || tx_ready;
  assign is_sof     = (pid_q == 4'b0101);
  assign crc5_field = is_sof ? frame_q : {endp_q, addr_q};
  assign b1_byte    = is_sof ? frame_q[7:0] : {endp_q[0], addr_q};
  // CRC5 MSB lands on bit 3 so the serialiser sends it first.
  assign b2_byte    = {rev5(crc5_f(crc5_field)), (is_sof ? frame_q[10:8] : endp_q[3:1])};
  assign crc16_out  = rev16(~crc16_q);
  assign reject     = (req_pid[1:0] == 2'b00) ||
                      ((req_pid[1:0] == 2'b11) && (req_len > MAX_LEN_W));

  assign req_ready = (state_q == IDLE);
  assign pl_ready  = (state_q == PAYLOAD) && slot_free && (cnt_q < len_q);
  assign pl_fire   = pl_valid && pl_ready;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign tx_sop    = tx_sop_q;
  assign tx_eop    = tx_eop_q;
  assign tx_pid_en = (state_q == PID);
  assign tx_pid    = pid_q;
  assign req_err   = err_q;

  always_comb begin
    state_d    = state_q;
    pid_d      = pid_q;
    addr_d     = addr_q;
    endp_d     = endp_q;
    frame_d    = frame_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    crc16_d    = crc16_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    tx_sop_d   = tx_sop_q;
    tx_eop_d   = tx_eop_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          pid_d   = req_pid;
          addr_d  = req_addr;
          endp_d  = req_endp;
          frame_d = req_frame;
          len_d   = req_len;
          cnt_d   = '0;
          crc16_d = '1;
          if (reject) begin
            err_d = 1'b1;
          end else begin
            state_d    = PID;
            tx_valid_d = 1'b1;
            tx_data_d  = {~req_pid, req_pid};
            tx_sop_d   = 1'b1;
            tx_eop_d   = (req_pid[1:0] == 2'b10);
          end
        end
      end
      PID: begin
        if (xfer) begin
          tx_sop_d = 1'b0;
          case (pid_q[1:0])
            2'b10: begin
              state_d    = IDLE;
              tx_valid_d = 1'b0;
              tx_eop_d   = 1'b0;
            end
            2'b11: begin
              if (len_q == '0) begin
                state_d   = CRC_LO;
                tx_data_d = crc16_out[7:0];
              end else begin
                state_d    = PAYLOAD;
                tx_valid_d = 1'b0;
              end
            end
            default: begin
              state_d   = B1;
              tx_data_d = b1_byte;
            end
          endcase
        end
      end
      B1: begin
        if (xfer) begin
          state_d   = B2;
          tx_data_d = b2_byte;
          tx_eop_d  = 1'b1;
        end
      end
      PAYLOAD: begin
        // The output slot is refilled from the payload stream, or from CRC_LO once
        // the last counted byte has left.
        if (xfer) tx_valid_d = 1'b0;
        if (pl_fire) begin
          tx_valid_d = 1'b1;
          tx_data_d  = pl_data;
          cnt_d      = cnt_q + LEN_W'(1);
          crc16_d    = crc16_byte(crc16_q, pl_data);
        end else if (xfer && (cnt_q == len_q)) begin
          state_d    = CRC_LO;
          tx_valid_d = 1'b1;
          tx_data_d  = crc16_out[7:0];
        end
      end
      CRC_LO: begin
        if (xfer) begin
          state_d   = CRC_HI;
          tx_data_d = crc16_out[15:8];
          tx_eop_d  = 1'b1;
        end
      end
      B2, CRC_HI: begin
        if (xfer) begin
          state_d    = IDLE;
          tx_valid_d = 1'b0;
          tx_eop_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pid_q      <= '0;
      addr_q     <= '0;
      endp_q     <= '0;
      frame_q    <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      crc16_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_sop_q   <= 1'b0;
      tx_eop_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pid_q      <= pid_d;
      addr_q     <= addr_d;
      endp_q     <= endp_d;
      frame_q    <= frame_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      crc16_q    <= crc16_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_sop_q   <= tx_sop_d;
      tx_eop_q   <= tx_eop_d;
      err_q      <= err_d;
    end
  end

endmodule
